if_id_queue: RTL and testbench
==============================

// Module: if_id_queue
// PURPOSE
//   Decoupling queue between if_stage and the decode stage. Holds up to DEPTH
//   fetched (pc, inst) pairs and presents the oldest to decode via valid/ready.
//   Absorbs decode stalls without re-fetching. A flush from a taken jump
//   discards all in-flight entries.
// PARAMETERS
//   DEPTH  4  number of entries; must be a power of 2, >= 2
//   PTR_W  2  log2(DEPTH); pointer width
// PORTS
//   clk          in   1        rising-edge clock
//   rst          in   1        synchronous, active-high reset
//   in_valid     in   1        if_stage presents a fetched instruction this cycle
//   in_ready     out  1        queue accepts it (push = in_valid & in_ready)
//   in_pc        in   `BUS_64  pc of the fetched instruction
//   in_inst      in   `BUS_32  fetched instruction word
//   flush        in   1        pc_jmp taken: discard all entries
//   out_valid    out  1        head entry valid toward decode
//   out_ready    in   1        decode consumes head (pop = out_valid & out_ready)
//   out_pc       out  `BUS_64  pc of head entry
//   out_inst     out  `BUS_32  instruction of head entry
//   out_misalign out  1        head pc[1:0] != 2'b00
//   count        out  PTR_W+1  current occupancy, 0..DEPTH
// BEHAVIOUR
//   - Reset (rst=1 at posedge): rd_ptr=0, wr_ptr=0, count=0. out_valid=0,
//     out_pc=0, out_inst=0, out_misalign=0, in_ready=1 in the following cycle.
//     Reset mid-operation drops every entry. Storage contents are don't-care.
//   - Storage: DEPTH x {pc[63:0], inst[31:0]} registers. The write takes effect
//     at the posedge where push=1.
//   - Latency: an entry pushed at edge N is first visible on out_* in cycle
//     N+1. There is no same-cycle bypass from in_* to out_*.
//   - in_ready = (count != DEPTH). It is a registered-state function only.
//     There is no combinational path from out_ready to in_ready. When full,
//     push is refused even if a pop happens in the same cycle.
//   - out_valid = (count != 0). When out_valid=0, out_pc, out_inst and
//     out_misalign are driven to 0 (not stale storage).
//   - Pop: rd_ptr <= rd_ptr+1 (mod DEPTH). Push: wr_ptr <= wr_ptr+1 (mod DEPTH).
//     Pointers wrap naturally at PTR_W bits.
//   - count update: push&!pop -> +1; pop&!push -> -1; both or neither -> hold.
//     Simultaneous push+pop on a non-full, non-empty queue keeps count
//     unchanged and preserves order.
//   - Empty + push + out_ready: no pop (out_valid=0), so count becomes 1.
//   - flush=1 (priority over push/pop): next cycle count=0, rd_ptr=wr_ptr=0,
//     out_valid=0. An in_valid beat in the flush cycle is discarded. The caller
//     must see no pop.
//   - rst has priority over flush.
//   - Overflow and underflow are impossible by construction. The assertions
//     count<=DEPTH and !(pop && count==0) must hold.
// STRUCTURE
//   - Widths come from defines.v (`BUS_64, `BUS_32). Add `IFQ_DEPTH 4 there as
//     the shared default. No new package.
//   - A single flat module: pointer/count control in one always@(posedge clk),
//     head mux in one always@(*).
//   - A generic sub-module sync_fifo_ctrl (pointers, count, full/empty) is
//     natural if the decode/exec queue reuses it.
// TESTING
//   1. Reset: assert rst 2 cycles, then release -> out_valid=0, in_ready=1,
//      count=0, out_pc=0.
//   2. Fill: push pc 0x8000_0000..0x8000_000C (inst 0x00000013 + i), out_ready=0
//      -> count=4, in_ready=0. A 5th push is refused and count stays 4.
//   3. Drain order: from full, out_ready=1 for 4 cycles -> out_pc 0x8000_0000,
//      0x8000_0004, 0x8000_0008, 0x8000_000C in order. Then out_valid=0.
//   4. Streaming wrap: push and pop every cycle for 10 cycles with count=1 ->
//      count stays 1, pointers wrap past 3->0, and pcs leave in push order with
//      1-cycle latency.
//   5. Flush: 3 entries, then flush=1 with in_valid=1, pc 0x8000_0100 ->
//      next cycle count=0, out_valid=0, and 0x8000_0100 never appears on out_pc.
//   6. Misalign and reset mid-run: push pc 0x8000_0002 -> out_misalign=1 at the
//      head. Then rst=1 with 2 entries -> count=0, out_valid=0 next cycle.

Source files
------------

// File: rtl/if_id_queue_pkg.sv
// Shared types and widths for the fetch/decode decoupling queue.
//   IfqDepth   default queue depth
//   BusPcW     program-counter width
//   BusInstW   instruction-word width
//   ifq_entry_t  one stored {pc, inst} pair
//   pc_misaligned  true when the low pc bits are not word aligned
package if_id_queue_pkg;

  localparam int unsigned IfqDepth = 4;
  localparam int unsigned BusPcW   = 64;
  localparam int unsigned BusInstW = 32;

  typedef struct packed {
    logic [BusPcW-1:0]   pc;
    logic [BusInstW-1:0] inst;
  } ifq_entry_t;

  function automatic logic pc_misaligned(input logic [1:0] pc_lsb);
    return pc_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/if_id_queue_ctrl.sv
// Generic synchronous FIFO control: read/write pointers, occupancy, full/empty.
//   clk_i       rising-edge clock
//   rst_i       synchronous active-high reset
//   flush_i     drop every entry; wins over push/pop
//   push_req_i  producer offers an entry
//   pop_req_i   consumer takes the head
//   push_o      accepted push (write enable for storage)
//   pop_o       accepted pop
//   wr_ptr_o    storage slot for the next push
//   rd_ptr_o    storage slot of the head
//   count_o     occupancy, 0..DEPTH
//   full_o      count_o == DEPTH
//   empty_o     count_o == 0
module if_id_queue_ctrl #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_req_i,
  input  logic             pop_req_i,
  output logic             push_o,
  output logic             pop_o,
  output logic [PTR_W-1:0] wr_ptr_o,
  output logic [PTR_W-1:0] rd_ptr_o,
  output logic [PTR_W:0]   count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam logic [PTR_W:0] CountFull = (PTR_W + 1)'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  // Full/empty depend on registered count only, so neither handshake
  // input reaches the opposite ready/valid combinationally.
  assign full_o  = (count_q == CountFull);
  assign empty_o = (count_q == '0);

  // A full queue refuses a push even when a pop happens in the same cycle.
  assign push_o = push_req_i & ~full_o & ~flush_i;
  assign pop_o  = pop_req_i & ~empty_o & ~flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_o) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_o)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push_o && !pop_o) begin
        count_d = count_q + (PTR_W + 1)'(1);
      end else if (pop_o && !push_o) begin
        count_d = count_q - (PTR_W + 1)'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign wr_ptr_o = wr_ptr_q;
  assign rd_ptr_o = rd_ptr_q;
  assign count_o  = count_q;

endmodule

// File: rtl/if_id_queue.sv
// Decoupling queue between the fetch stage and decode. Holds up to DEPTH
// fetched {pc, inst} pairs and presents the oldest to decode via valid/ready.
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   in_valid     fetch presents an instruction
//   in_ready     queue can accept (registered-state function only)
//   in_pc        pc of the fetched instruction
//   in_inst      fetched instruction word
//   flush        taken jump: discard all entries
//   out_valid    head entry valid toward decode
//   out_ready    decode consumes the head
//   out_pc       head pc (0 when empty)
//   out_inst     head instruction (0 when empty)
//   out_misalign head pc[1:0] != 0 (0 when empty)
//   count        occupancy, 0..DEPTH
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int unsigned DEPTH = IfqDepth,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BusPcW-1:0]   in_pc,
  input  logic [BusInstW-1:0] in_inst,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BusPcW-1:0]   out_pc,
  output logic [BusInstW-1:0] out_inst,
  output logic                out_misalign,
  output logic [PTR_W:0]      count
);

  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  ifq_entry_t mem_q [DEPTH];
  ifq_entry_t head;

  if_id_queue_ctrl #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_ctrl (
    .clk_i      (clk),
    .rst_i      (rst),
    .flush_i    (flush),
    .push_req_i (in_valid),
    .pop_req_i  (out_ready),
    .push_o     (push),
    .pop_o      (pop),
    .wr_ptr_o   (wr_ptr),
    .rd_ptr_o   (rd_ptr),
    .count_o    (count),
    .full_o     (full),
    .empty_o    (empty)
  );

  assign in_ready  = ~full;
  assign out_valid = ~empty;

  // Storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr] <= '{pc: in_pc, inst: in_inst};
    end
  end

  // Empty queue drives zeros rather than stale storage.
  always_comb begin
    head         = mem_q[rd_ptr];
    out_pc       = '0;
    out_inst     = '0;
    out_misalign = 1'b0;
    if (!empty) begin
      out_pc       = head.pc;
      out_inst     = head.inst;
      out_misalign = pc_misaligned(head.pc[1:0]);
    end
  end

  a_count_bound : assert property (@(posedge clk) disable iff (rst) 32'(count) <= DEPTH);
  a_no_underflow : assert property (@(posedge clk) disable iff (rst) !(pop && empty));

endmodule

// File: tb/tb_if_id_queue.sv
module tb_if_id_queue;

  localparam int unsigned Depth = 4;
  localparam int unsigned PtrW  = 2;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [63:0]   in_pc;
  logic [31:0]   in_inst;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [63:0]   out_pc;
  logic [31:0]   out_inst;
  logic          out_misalign;
  logic [PtrW:0] count;

  if_id_queue #(
    .DEPTH (Depth),
    .PTR_W (PtrW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_pc        (in_pc),
    .in_inst      (in_inst),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc       (out_pc),
    .out_inst     (out_inst),
    .out_misalign (out_misalign),
    .count        (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
  } ent_t;

  // Expected contents, oldest first. Entries go in when a push is issued and
  // come out when decode takes the head.
  ent_t exp_q[$];
  bit   model_known = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: at each negedge compare the visible state with the model, then
  // apply the inputs that the coming posedge will sample.
  always @(negedge clk) begin
    int unsigned sz;
    bit          q_full;
    ent_t        e;
    if (model_known) begin
      sz = exp_q.size();
      check("count", 64'(count), 64'(sz));
      check("out_valid", 64'(out_valid), 64'(sz != 0));
      check("in_ready", 64'(in_ready), 64'(sz != Depth));
      if (sz != 0) begin
        check("head_pc", out_pc, exp_q[0].pc);
        check("head_inst", 64'(out_inst), 64'(exp_q[0].inst));
        check("head_misalign", 64'(out_misalign), 64'(exp_q[0].pc[1:0] != 2'b00));
      end else begin
        check("empty_pc", out_pc, 64'h0);
        check("empty_inst", 64'(out_inst), 64'h0);
        check("empty_misalign", 64'(out_misalign), 64'h0);
      end
    end
    if (rst) begin
      exp_q.delete();
      model_known = 1'b1;
    end else if (model_known) begin
      if (flush) begin
        exp_q.delete();
      end else begin
        q_full = (exp_q.size() == Depth);
        if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
        if (in_valid && !q_full) begin
          e.pc   = in_pc;
          e.inst = in_inst;
          exp_q.push_back(e);
        end
      end
    end
  end

  // Set inputs, then let one posedge sample them; returns 1 time unit later.
  task automatic drive(input bit v, input logic [63:0] pc, input logic [31:0] inst,
                       input bit rdy, input bit fl, input bit r);
    in_valid  = v;
    in_pc     = pc;
    in_inst   = inst;
    out_ready = rdy;
    flush     = fl;
    rst       = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    in_valid  = 1'b0;
    in_pc     = '0;
    in_inst   = '0;
    out_ready = 1'b0;
    flush     = 1'b0;
    rst       = 1'b1;

    // Reset
    drive(0, 64'h0, 32'h0, 0, 0, 1);
    drive(0, 64'h0, 32'h0, 0, 0, 1);
    rst = 1'b0;
    check("rst_out_valid", 64'(out_valid), 64'h0);
    check("rst_in_ready", 64'(in_ready), 64'h1);
    check("rst_count", 64'(count), 64'h0);
    check("rst_out_pc", out_pc, 64'h0);

    // Fill, then a refused fifth push
    for (int i = 0; i < 4; i++) begin
      drive(1, 64'h8000_0000 + 64'(4 * i), 32'h13 + 32'(i), 0, 0, 0);
    end
    check("fill_count", 64'(count), 64'd4);
    check("fill_in_ready", 64'(in_ready), 64'h0);
    drive(1, 64'h8000_0010, 32'h17, 0, 0, 0);
    check("overfill_count", 64'(count), 64'd4);

    // Drain in order
    for (int i = 0; i < 4; i++) begin
      check("drain_pc", out_pc, 64'h8000_0000 + 64'(4 * i));
      drive(0, 64'h0, 32'h0, 1, 0, 0);
    end
    check("drained_valid", 64'(out_valid), 64'h0);

    // Streaming with one entry in flight, wrapping the pointers
    drive(1, 64'h8000_0200, 32'h100, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      drive(1, 64'h8000_0204 + 64'(4 * i), 32'h101 + 32'(i), 1, 0, 0);
      check("stream_count", 64'(count), 64'd1);
      check("stream_pc", out_pc, 64'h8000_0204 + 64'(4 * i));
    end
    drive(0, 64'h0, 32'h0, 1, 0, 0);

    // Flush with a concurrent push that must be dropped
    for (int i = 0; i < 3; i++) begin
      drive(1, 64'h8000_0300 + 64'(4 * i), 32'h200 + 32'(i), 0, 0, 0);
    end
    drive(1, 64'h8000_0100, 32'hdead, 0, 1, 0);
    check("flush_count", 64'(count), 64'h0);
    check("flush_valid", 64'(out_valid), 64'h0);
    drive(0, 64'h0, 32'h0, 1, 0, 0);
    check("flush_no_leak", out_pc, 64'h0);

    // Misaligned head, then reset with entries in flight
    drive(1, 64'h8000_0002, 32'h13, 0, 0, 0);
    check("misalign_head", 64'(out_misalign), 64'h1);
    drive(1, 64'h8000_0008, 32'h14, 0, 0, 0);
    check("pre_rst_count", 64'(count), 64'd2);
    drive(0, 64'h0, 32'h0, 0, 0, 1);
    check("midrst_count", 64'(count), 64'h0);
    check("midrst_valid", 64'(out_valid), 64'h0);

    // Randomised traffic with occasional flush and reset
    for (int i = 0; i < 800; i++) begin
      logic [63:0] pc;
      pc = {32'h8000_0000, $urandom};
      if ($urandom_range(0, 3) != 0) pc[1:0] = 2'b00;
      drive(bit'($urandom_range(0, 1)), pc, $urandom, bit'($urandom_range(0, 2) != 0),
            $urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0);
    end
    drive(0, 64'h0, 32'h0, 1, 0, 0);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
